// File: rtl/ysyx_24100006_pipe_stage.sv
// Valid/ready pipeline register with synchronous flush and an optional two-entry skid buffer.
// Defining YSYX_24100006_PIPE_STAGE_PERF_EN adds saturating stall_cnt/bubble_cnt counters.
module ysyx_24100006_pipe_stage #(
    parameter int unsigned DATA_W     = 32,
    parameter bit          SKID       = 1'b1,
    parameter bit          CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef YSYX_24100006_PIPE_STAGE_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [DATA_W-1:0] out_data
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    // With the skid buffer, ready depends only on a flop, breaking the upstream ready chain.
    assign in_ready  = SKID ? !skid_valid_q : (!main_valid_q || out_ready);
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (SKID && skid_valid_q) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (out_ready) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!main_valid_q || out_ready) begin
            main_valid_d = in_valid;
            if (in_valid) begin
                main_data_d = in_data;
            end
        end else if (SKID && in_valid) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // NOTE: payload flops are only reset when CLEAR_DATA asks for it; otherwise they carry no reset.
    always_ff @(posedge clk) begin
        if (reset && CLEAR_DATA) begin
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef YSYX_24100006_PIPE_STAGE_PERF_EN
    logic [31:0] stall_q, bubble_q;

    // Counters observe the handshake only and survive flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_valid_q && !out_ready && stall_q != 32'hFFFF_FFFF) begin
                stall_q <= stall_q + 32'd1;
            end
            if (!main_valid_q && out_ready && bubble_q != 32'hFFFF_FFFF) begin
                bubble_q <= bubble_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_ysyx_24100006_pipe_stage.sv
// Directed bench for ysyx_24100006_pipe_stage: a SKID=1 and a SKID=0 instance, with emitted
// payloads checked in order against a scoreboard queue by a separate monitor.
module tb_ysyx_24100006_pipe_stage;

    logic        clk = 1'b0;
    logic        reset;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
`ifdef YSYX_24100006_PIPE_STAGE_PERF_EN
    logic [31:0] s_stall_cnt, s_bubble_cnt, n_stall_cnt, n_bubble_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] sb_s[$];
    logic [31:0] sb_n[$];

    always #5 clk = ~clk;

    ysyx_24100006_pipe_stage #(.DATA_W(32), .SKID(1'b1), .CLEAR_DATA(1'b1)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (s_flush),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
`ifdef YSYX_24100006_PIPE_STAGE_PERF_EN
        .stall_cnt (s_stall_cnt),
        .bubble_cnt(s_bubble_cnt),
`endif
        .out_data  (s_out_data)
    );

    ysyx_24100006_pipe_stage #(.DATA_W(32), .SKID(1'b0), .CLEAR_DATA(1'b1)) u_noskid (
        .clk       (clk),
        .reset     (reset),
        .flush     (n_flush),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_data   (n_in_data),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
`ifdef YSYX_24100006_PIPE_STAGE_PERF_EN
        .stall_cnt (n_stall_cnt),
        .bubble_cnt(n_bubble_cnt),
`endif
        .out_data  (n_out_data)
    );

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every downstream transfer must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (!reset && s_out_valid && s_out_ready) begin
            if (sb_s.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL skid_unexpected_emit: got %h expected nothing at %0t", s_out_data, $time);
            end else begin
                check("skid_emit", s_out_data, sb_s.pop_front());
            end
        end
        if (!reset && n_out_valid && n_out_ready) begin
            if (sb_n.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL noskid_unexpected_emit: got %h expected nothing at %0t", n_out_data, $time);
            end else begin
                check("noskid_emit", n_out_data, sb_n.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] t1_data [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        reset = 1'b1;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
        step();
        step();
        check("rst_s_out_valid", {31'b0, s_out_valid}, 32'd0);
        check("rst_s_in_ready",  {31'b0, s_in_ready},  32'd1);
        check("rst_s_out_data",  s_out_data,           32'd0);
        check("rst_n_out_valid", {31'b0, n_out_valid}, 32'd0);
        check("rst_n_in_ready",  {31'b0, n_in_ready},  32'd1);
        reset = 1'b0;

        // Streaming at full rate: one cycle latency, in_ready never drops.
        s_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_in_valid = 1'b1;
            s_in_data  = t1_data[i];
            check("t1_in_ready", {31'b0, s_in_ready}, 32'd1);
            sb_s.push_back(t1_data[i]);
            step();
            check("t1_out_valid", {31'b0, s_out_valid}, 32'd1);
            check("t1_out_data",  s_out_data,           t1_data[i]);
        end
        s_in_valid = 1'b0;
        step();
        check("t1_drained", {31'b0, s_out_valid}, 32'd0);

        // Stall fills the skid entry; 0xDD offered while full must never be taken.
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hA; sb_s.push_back(32'hA);
        step();
        s_in_data = 32'hB; sb_s.push_back(32'hB);
        check("t2_ready_before_b", {31'b0, s_in_ready}, 32'd1);
        step();
        s_in_data = 32'hDD;
        check("t2_ready_after_b", {31'b0, s_in_ready}, 32'd0);
        check("t2_hold_a",        s_out_data,          32'hA);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_stall_data",  s_out_data,           32'hA);
            check("t2_stall_ready", {31'b0, s_in_ready},  32'd0);
        end
        s_out_ready = 1'b1;
        step();
        s_in_valid = 1'b0;
        check("t2_b_moved",    s_out_data,          32'hB);
        check("t2_ready_back", {31'b0, s_in_ready}, 32'd1);
        step();
        check("t2_drained", {31'b0, s_out_valid}, 32'd0);

        // Flush with both entries full: A/B are killed, C is discarded, nothing is emitted.
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'hA;
        step();
        s_in_data = 32'hB;
        step();
        s_in_data = 32'hC; s_flush = 1'b1;
        step();
        s_flush = 1'b0; s_in_valid = 1'b0;
        check("t3_out_valid", {31'b0, s_out_valid}, 32'd0);
        check("t3_out_data",  s_out_data,           32'd0);
        check("t3_in_ready",  {31'b0, s_in_ready},  32'd1);
        s_out_ready = 1'b1;
        step();
        step();
        check("t3_still_empty", {31'b0, s_out_valid}, 32'd0);

        // Flush coinciding with an emit: D still transfers, nothing remains.
        s_in_valid = 1'b1; s_in_data = 32'hD; sb_s.push_back(32'hD);
        step();
        s_in_valid = 1'b0; s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        check("t3_flush_emit_empty", {31'b0, s_out_valid}, 32'd0);

        // Flush while empty changes nothing; the stage keeps working afterwards.
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        check("t3_empty_flush_ready", {31'b0, s_in_ready}, 32'd1);
        s_in_valid = 1'b1; s_in_data = 32'hE; sb_s.push_back(32'hE);
        step();
        s_in_valid = 1'b0;
        check("t3_after_flush_data", s_out_data, 32'hE);
        step();

        // Single-register stage: full stage with a stalled consumer blocks input.
        n_out_ready = 1'b0;
        n_in_valid = 1'b1; n_in_data = 32'h5; sb_n.push_back(32'h5);
        check("t4_ready_empty", {31'b0, n_in_ready}, 32'd1);
        step();
        n_in_data = 32'h6;
        check("t4_ready_full", {31'b0, n_in_ready}, 32'd0);
        step();
        check("t4_hold_5",       n_out_data,          32'h5);
        check("t4_ready_stalled", {31'b0, n_in_ready}, 32'd0);
        n_out_ready = 1'b1;
        #1;
        check("t4_ready_comb", {31'b0, n_in_ready}, 32'd1);
        sb_n.push_back(32'h6);
        step();
        n_in_valid = 1'b0;
        check("t4_load_6",  n_out_data,           32'h6);
        check("t4_valid_6", {31'b0, n_out_valid}, 32'd1);
        step();
        check("t4_drained", {31'b0, n_out_valid}, 32'd0);

        // Reset in the middle of a full stall drops both entries.
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'h5A;
        step();
        s_in_data = 32'h5B;
        step();
        s_in_valid = 1'b0;
        check("t5_full", {31'b0, s_in_ready}, 32'd0);
        reset = 1'b1;
        step();
        check("t5_out_valid", {31'b0, s_out_valid}, 32'd0);
        check("t5_in_ready",  {31'b0, s_in_ready},  32'd1);
        check("t5_out_data",  s_out_data,           32'd0);
        reset = 1'b0;

`ifdef YSYX_24100006_PIPE_STAGE_PERF_EN
        // Three stalled cycles, one emit, then two bubbles; flush must not touch the counts.
        reset = 1'b1;
        step();
        reset = 1'b0;
        s_out_ready = 1'b0;
        s_in_valid = 1'b1; s_in_data = 32'h77; sb_s.push_back(32'h77);
        step();
        s_in_valid = 1'b0;
        step();
        step();
        step();
        s_out_ready = 1'b1;
        step();
        step();
        step();
        s_out_ready = 1'b0;
        step();
        check("t6_stall_cnt",  s_stall_cnt,  32'd3);
        check("t6_bubble_cnt", s_bubble_cnt, 32'd2);
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        check("t6_stall_after_flush",  s_stall_cnt,  32'd3);
        check("t6_bubble_after_flush", s_bubble_cnt, 32'd2);
`endif

        step();
        step();
        check("sb_skid_empty",   sb_s.size(), 32'd0);
        check("sb_noskid_empty", sb_n.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
